// File: rtl/staged_register_pkg.sv
// Shared constants and helpers for the staged_register pipeline.
// Optional build macro: STAGED_REGISTER_PARITY_EN (per-stage even-parity bit and parity_err output).
package staged_register_pkg;

  // Values held by an empty stage.
  localparam logic VALID_RESET    = 1'b0;
  localparam logic DATA_RESET_BIT = 1'b0;
  localparam logic PARITY_RESET   = 1'b0;

  // Bits needed to count 0..stages valid entries.
  function automatic int unsigned occ_width(input int unsigned stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/staged_register_if.sv
// Producer/consumer handshake bundle for staged_register.
// Optional build macro: STAGED_REGISTER_PARITY_EN adds parity_err.
interface staged_register_if
  import staged_register_pkg::*;
#(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned STAGES = 3
);

  localparam int unsigned OCC_W = occ_width(STAGES);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             flush;
  logic [OCC_W-1:0] occupancy;
`ifdef STAGED_REGISTER_PARITY_EN
  logic             parity_err;
`endif

  // Environment side: producer, consumer and flush control.
  modport master (
`ifdef STAGED_REGISTER_PARITY_EN
    input  parity_err,
`endif
    output in_valid,
    input  in_ready,
    output din,
    input  out_valid,
    output out_ready,
    input  dout,
    output flush,
    input  occupancy
  );

  // Pipeline side.
  modport slave (
`ifdef STAGED_REGISTER_PARITY_EN
    output parity_err,
`endif
    input  in_valid,
    output in_ready,
    input  din,
    output out_valid,
    input  out_ready,
    output dout,
    input  flush,
    output occupancy
  );

endinterface

// File: rtl/staged_register_stage.sv
// One pipeline stage: valid bit plus data word with hold / load / clear.
// Optional build macro: STAGED_REGISTER_PARITY_EN stores an even-parity bit alongside the data.
module staged_register_stage
  import staged_register_pkg::*;
#(
  parameter int unsigned WIDTH      = 7,
  parameter bit          CLEAR_IDLE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
`ifdef STAGED_REGISTER_PARITY_EN
  input  logic             parity_in,
  output logic             parity,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] load_data_c;

  // An empty word is zeroed on entry when idle clearing is enabled.
  always_comb begin
    load_data_c = data_in;
    if (CLEAR_IDLE && !valid_in) begin
      load_data_c = {WIDTH{DATA_RESET_BIT}};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= VALID_RESET;
      data  <= {WIDTH{DATA_RESET_BIT}};
    end else if (flush) begin
      valid <= VALID_RESET;
      if (CLEAR_IDLE) begin
        data <= {WIDTH{DATA_RESET_BIT}};
      end
    end else if (load) begin
      valid <= valid_in;
      data  <= load_data_c;
    end
  end

`ifdef STAGED_REGISTER_PARITY_EN
  logic load_parity_c;

  always_comb begin
    load_parity_c = parity_in;
    if (CLEAR_IDLE && !valid_in) begin
      load_parity_c = PARITY_RESET;
    end
  end

  // Parity travels with its word and follows the same clear rules.
  always_ff @(posedge clock) begin
    if (reset) begin
      parity <= PARITY_RESET;
    end else if (flush) begin
      if (CLEAR_IDLE) begin
        parity <= PARITY_RESET;
      end
    end else if (load) begin
      parity <= load_parity_c;
    end
  end
`endif

endmodule

// File: rtl/staged_register.sv
// Elastic STAGES-deep pipeline register with valid/ready handshake, flush and occupancy.
// Optional build macro: STAGED_REGISTER_PARITY_EN enables per-stage parity and parity_err.
module staged_register
  import staged_register_pkg::*;
#(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned STAGES     = 3,
  parameter bit          CLEAR_IDLE = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  staged_register_if.slave  bus
);

  localparam int unsigned OCC_W = occ_width(STAGES);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  data     [STAGES];
  logic [WIDTH-1:0]  src_data [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic              in_ready_c;
  logic              in_xfer_c;
  logic              out_xfer_c;

`ifdef STAGED_REGISTER_PARITY_EN
  logic [STAGES-1:0] par;
  logic [STAGES-1:0] src_par;
`endif

  // Stage k can load when it or any stage downstream has a hole, or the consumer takes.
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign rdy[k] = bus.out_ready | ~(&vld[STAGES-1:k]);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_vld[k]  = bus.in_valid & ~bus.flush;
      assign src_data[k] = bus.din;
`ifdef STAGED_REGISTER_PARITY_EN
      assign src_par[k]  = ^bus.din;
`endif
    end else begin : g_body
      assign src_vld[k]  = vld[k-1];
      assign src_data[k] = data[k-1];
`ifdef STAGED_REGISTER_PARITY_EN
      assign src_par[k]  = par[k-1];
`endif
    end

    staged_register_stage #(
      .WIDTH      (WIDTH),
      .CLEAR_IDLE (CLEAR_IDLE)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .flush     (bus.flush),
      .load      (rdy[k]),
      .valid_in  (src_vld[k]),
      .data_in   (src_data[k]),
`ifdef STAGED_REGISTER_PARITY_EN
      .parity_in (src_par[k]),
      .parity    (par[k]),
`endif
      .valid     (vld[k]),
      .data      (data[k])
    );
  end

  assign in_ready_c = rdy[0] & ~bus.flush;
  assign in_xfer_c  = bus.in_valid & in_ready_c;
  assign out_xfer_c = vld[STAGES-1] & bus.out_ready;

  // Occupancy tracks the stage valids: +1 per accepted word, -1 per delivered word.
  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= '0;
    end else if (bus.flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(in_xfer_c) - OCC_W'(out_xfer_c);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.dout      = data[STAGES-1];
  assign bus.occupancy = occ_q;

`ifdef STAGED_REGISTER_PARITY_EN
  assign bus.parity_err = vld[STAGES-1] & ((^data[STAGES-1]) != par[STAGES-1]);
`endif

endmodule

// File: tb/tb_staged_register.sv
// Directed scoreboard bench for staged_register (WIDTH=7, STAGES=3).
// With STAGED_REGISTER_PARITY_EN defined the DUT is built with CLEAR_IDLE=0 and parity is exercised.
module tb_staged_register;

  localparam int unsigned W = 7;
  localparam int unsigned S = 3;
`ifdef STAGED_REGISTER_PARITY_EN
  localparam bit CI = 1'b0;
`else
  localparam bit CI = 1'b1;
`endif

  logic clock;
  logic reset;

  staged_register_if #(.WIDTH(W), .STAGES(S)) bus ();

  staged_register #(
    .WIDTH      (W),
    .STAGES     (S),
    .CLEAR_IDLE (CI)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int passed;
  int failed;
  int total;
  int model_occ;
  int cyc;
  int first_acc;
  int first_out;
  int last_out;
  bit acc_flag;
  bit corrupt;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict handshake, score outputs, advance the model, then check occupancy.
  task automatic cycle();
    bit exp_rdy;
    bit acc;
    bit taken;
    #1;
    exp_rdy = !bus.flush && (model_occ < int'(S) || bus.out_ready);
    check("in_ready", bus.in_ready, exp_rdy);
    if (model_occ == 0) check("out_valid_empty", bus.out_valid, 0);
`ifndef STAGED_REGISTER_PARITY_EN
    if (!bus.out_valid) check("dout_idle_zero", bus.dout, 0);
`else
    if (!corrupt) check("parity_clean", bus.parity_err, 0);
`endif
    acc   = bus.in_valid && exp_rdy;
    taken = bus.out_valid && bus.out_ready;
    if (acc && first_acc < 0) first_acc = cyc;
    if (bus.out_valid && first_out < 0) first_out = cyc;
    if (taken) begin
      if (exp_q.size() == 0) begin
        total++;
        assert (exp_q.size() > 0) passed++;
        else begin
          failed++;
          $error("FAIL unexpected_out: observed dout 0x%0h expected no output", bus.dout);
        end
      end else begin
        check("dout", bus.dout, exp_q.pop_front());
      end
      last_out = cyc;
    end
    if (bus.flush) begin
      exp_q.delete();
      model_occ = 0;
    end else begin
      if (acc) begin
        exp_q.push_back(bus.din);
        model_occ++;
      end
      if (taken) model_occ--;
    end
    acc_flag = acc;
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check("occupancy", bus.occupancy, model_occ);
  endtask

  task automatic push(input logic [W-1:0] w, input int budget);
    bus.in_valid = 1'b1;
    bus.din      = w;
    acc_flag     = 1'b0;
    for (int i = 0; i < budget && !acc_flag; i++) cycle();
    check("push_accepted", acc_flag, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle();
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    passed = 0; failed = 0; total = 0;
    model_occ = 0; cyc = 0; first_acc = -1; first_out = -1; last_out = 0;
    acc_flag = 1'b0; corrupt = 1'b0;
    bus.in_valid = 1'b0; bus.din = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
    reset = 1'b1;

    // Reset with a word offered: nothing may be captured.
    bus.in_valid = 1'b1;
    bus.din      = 7'h55;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_occupancy", bus.occupancy, 0);
    bus.out_ready = 1'b1;
    repeat (4) cycle();

    // Streaming 01..0A back to back.
    first_acc = -1; first_out = -1;
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = 1'b1;
      bus.din      = W'(i);
      cycle();
    end
    bus.in_valid = 1'b0;
    drain(10);
    check("stream_latency", first_out - first_acc, 3);
    check("stream_no_gaps", last_out - first_out, 9);

    // Backpressure: fourth word waits until the consumer releases.
    bus.out_ready = 1'b0;
    push(7'h11, 4);
    push(7'h22, 4);
    push(7'h33, 4);
    check("bp_occupancy", bus.occupancy, 3);
    bus.in_valid = 1'b1;
    bus.din      = 7'h44;
    #1 check("bp_in_ready", bus.in_ready, 0);
    repeat (2) cycle();
    bus.out_ready = 1'b1;
    push(7'h44, 4);
    drain(10);

    // Full pipe with simultaneous input and output.
    bus.out_ready = 1'b0;
    push(7'h61, 4);
    push(7'h62, 4);
    push(7'h63, 4);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.din       = 7'h7F;
    #1 check("full_in_ready", bus.in_ready, 1);
    cycle();
    bus.in_valid = 1'b0;
    check("full_occupancy", bus.occupancy, 3);
    drain(10);

    // Flush with two words held and a word offered.
    bus.out_ready = 1'b0;
    push(7'h0B, 4);
    push(7'h0C, 4);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.din      = 7'h2A;
    #1 check("flush_in_ready", bus.in_ready, 0);
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_occupancy", bus.occupancy, 0);
    check("flush_out_valid", bus.out_valid, 0);
`ifndef STAGED_REGISTER_PARITY_EN
    check("flush_dout", bus.dout, 0);
`endif
    bus.out_ready = 1'b1;
    repeat (5) cycle();

    // Flush while the consumer takes the head word.
    bus.out_ready = 1'b0;
    push(7'h0D, 4);
    push(7'h0E, 4);
    push(7'h0F, 4);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    cycle();
    bus.flush = 1'b0;
    check("flush_take_occupancy", bus.occupancy, 0);
    repeat (4) cycle();

`ifdef STAGED_REGISTER_PARITY_EN
    // Corrupt the word sitting in the last stage.
    bus.out_ready = 1'b0;
    push(7'h21, 4);
    push(7'h42, 4);
    push(7'h63, 4);
    corrupt = 1'b1;
    force dut.g_stage[2].u_stage.data = 7'h25;
    #1 check("parity_err_set", bus.parity_err, 1);
    release dut.g_stage[2].u_stage.data;
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    check("parity_err_after_flush", bus.parity_err, 0);
    corrupt = 1'b0;
    bus.out_ready = 1'b1;
    push(7'h35, 4);
    push(7'h4C, 4);
    drain(10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
